// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through byte FIFO between uart_rx and ram_rw.
// Occupancy is tracked in an explicit level register, and the flags are decoded from it.
// Overflow is a sticky flag.
// Flush clears pointers and level but leaves the overflow flag alone.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 8,
  parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic [DW-1:0] in_data_i,
  input  logic          in_data_vld_i,
  output logic          in_data_rdy_o,
  output logic [DW-1:0] out_data_o,
  output logic          out_data_vld_o,
  input  logic          out_data_rdy_i,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          overflow_o,
  input  logic          overflow_clr_i
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          full, empty;
  logic          wr_en, rd_en;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  // Writes are refused when full even if a pop happens on the same edge.
  // Flush and reset discard any transfer.
  assign wr_en = in_data_vld_i && !full && !flush_i && !rst_i;
  assign rd_en = out_data_rdy_i && !empty && !flush_i;

  // Next-state computation for the pointers, the level and the sticky overflow flag
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (wr_en) wptr_d = wptr_q + AW'(1);
      if (rd_en) rptr_d = rptr_q + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
    // A set takes priority over a clear on the same edge.
    if (overflow_clr_i) ovf_d = 1'b0;
    if (in_data_vld_i && full) ovf_d = 1'b1;
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage array; contents are never reset
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q] <= in_data_i;
  end

  // The head is forced to zero while empty, so that reset yields a defined output.
  assign out_data_o     = empty ? '0 : mem_q[rptr_q];
  assign out_data_vld_o = ~empty;
  assign in_data_rdy_o  = ~full;
  assign full_o         = full;
  assign empty_o        = empty;
  assign level_o        = level_q;
  assign overflow_o     = ovf_q;

endmodule
